// File: rtl/dsi_line_fetch_pkg.sv
// Shared types and elaboration helpers for the DSI line-fetch controller.
package dsi_line_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StPad,
        StDrain
    } fetch_state_e;

    // Bits needed to hold values 0..value-1 (minimum 1).
    function automatic int unsigned bits_for(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) begin
            width++;
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/dsi_line_fetch_out_reg.sv
// One-entry valid/ready output register: loads when slot is free, holds under back-pressure.
module dsi_line_fetch_out_reg #(
    parameter int unsigned DW   = 24,
    parameter logic [DW-1:0] FILL = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [DW-1:0] load_data_i,
    input  logic          load_last_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          last_o,
    output logic          slot_o
);

    logic          valid_q;
    logic [DW-1:0] data_q;
    logic          last_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= FILL;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= load_data_i;
            last_q  <= load_last_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign slot_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/dsi_line_fetch.sv
// Pops one H_ACTIVE-word line from an FWFT FIFO per line_start, padding with FILL on starvation.
module dsi_line_fetch
    import dsi_line_fetch_pkg::*;
#(
    parameter int unsigned   DW       = 24,
    parameter int unsigned   H_ACTIVE = 480,
    parameter int unsigned   CW       = 12,
    parameter int unsigned   WAIT_MAX = 255,
    parameter logic [DW-1:0] FILL     = '0
) (
    input  logic          r_clk,
    input  logic          r_rst,
    input  logic          line_start,
    output logic          line_busy,
    output logic          line_done,
    input  logic [DW-1:0] fifo_rdata,
    input  logic          fifo_empty,
    output logic          fifo_re,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          underflow,
    output logic          overrun,
    input  logic          err_clr,
    output logic [CW-1:0] pix_cnt
);

    localparam int unsigned   SW       = bits_for(WAIT_MAX + 1);
    localparam logic [CW-1:0] LastIdx  = CW'(H_ACTIVE - 1);
    localparam logic [SW-1:0] StallLim = SW'(WAIT_MAX - 1);

    if (bits_for(H_ACTIVE + 1) > CW) begin : g_cw_too_narrow
        $error("dsi_line_fetch: CW too narrow to count H_ACTIVE words");
    end

    fetch_state_e  state_q, state_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          underflow_q, underflow_d;
    logic          overrun_q, overrun_d;
    logic          done_q, done_d;

    logic          fifo_pop;
    logic          uf_set;
    logic          load;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          slot;

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        stall_d   = stall_q;
        fifo_pop  = 1'b0;
        uf_set    = 1'b0;
        load      = 1'b0;
        load_data = FILL;
        load_last = (pix_cnt_q == LastIdx);
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (line_start) begin
                    state_d   = StStream;
                    pix_cnt_d = '0;
                    stall_d   = '0;
                end
            end
            StStream: begin
                if (slot && !fifo_empty) begin
                    fifo_pop  = 1'b1;
                    load      = 1'b1;
                    load_data = fifo_rdata;
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    stall_d   = '0;
                    if (pix_cnt_q == LastIdx) begin
                        state_d = StDrain;
                    end
                end else if (slot) begin
                    // Only cycles where a word could have been taken count as starved.
                    stall_d = stall_q + 1'b1;
                    if (stall_q == StallLim) begin
                        state_d = StPad;
                        uf_set  = 1'b1;
                    end
                end
            end
            StPad: begin
                if (slot) begin
                    load      = 1'b1;
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    if (pix_cnt_q == LastIdx) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (out_valid && out_ready) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A set in the same cycle as err_clr wins.
        underflow_d = uf_set || (underflow_q && !err_clr);
        overrun_d   = (line_start && (state_q != StIdle)) || (overrun_q && !err_clr);
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state_q     <= StIdle;
            pix_cnt_q   <= '0;
            stall_q     <= '0;
            underflow_q <= 1'b0;
            overrun_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            stall_q     <= stall_d;
            underflow_q <= underflow_d;
            overrun_q   <= overrun_d;
            done_q      <= done_d;
        end
    end

    dsi_line_fetch_out_reg #(
        .DW   (DW),
        .FILL (FILL)
    ) u_out_reg (
        .clk_i       (r_clk),
        .rst_i       (r_rst),
        .load_i      (load),
        .load_data_i (load_data),
        .load_last_i (load_last),
        .ready_i     (out_ready),
        .valid_o     (out_valid),
        .data_o      (out_data),
        .last_o      (out_last),
        .slot_o      (slot)
    );

    // Never pop during reset so an aborted line leaves the FIFO intact.
    assign fifo_re   = fifo_pop && !r_rst;
    assign line_busy = (state_q != StIdle);
    assign line_done = done_q;
    assign underflow = underflow_q;
    assign overrun   = overrun_q;
    assign pix_cnt   = pix_cnt_q;

endmodule

// File: tb/tb_dsi_line_fetch.sv
// Scoreboard bench for dsi_line_fetch with a small FWFT FIFO model, H_ACTIVE=8, WAIT_MAX=4.
module tb_dsi_line_fetch;

    localparam int unsigned DW    = 24;
    localparam int unsigned H     = 8;
    localparam int unsigned CW    = 4;
    localparam int unsigned WM    = 4;
    localparam logic [23:0] FILLW = 24'hF111F1;

    logic          r_clk;
    logic          r_rst;
    logic          line_start;
    logic          line_busy;
    logic          line_done;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_empty;
    logic          fifo_re;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic          underflow;
    logic          overrun;
    logic          err_clr;
    logic [CW-1:0] pix_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW:0] exp_q[$];
    logic        mon_en = 1'b0;
    logic        toggle_en = 1'b0;

    logic [23:0] mem [0:127];
    int          wr_idx = 0;
    int          rd_idx = 0;

    dsi_line_fetch #(
        .DW       (DW),
        .H_ACTIVE (H),
        .CW       (CW),
        .WAIT_MAX (WM),
        .FILL     (FILLW)
    ) dut (
        .r_clk      (r_clk),
        .r_rst      (r_rst),
        .line_start (line_start),
        .line_busy  (line_busy),
        .line_done  (line_done),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_re    (fifo_re),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .underflow  (underflow),
        .overrun    (overrun),
        .err_clr    (err_clr),
        .pix_cnt    (pix_cnt)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    // FWFT FIFO model
    assign fifo_empty = (rd_idx == wr_idx);
    assign fifo_rdata = mem[rd_idx[6:0]];

    always @(posedge r_clk) begin
        if (fifo_re && !fifo_empty) rd_idx <= rd_idx + 1;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge r_clk);
            #1;
            out_ready = toggle_en ? !out_ready : 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fifo_fill(input logic [23:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_idx[6:0]] = first + 24'(i);
            wr_idx++;
        end
    endtask

    task automatic exp_push(input logic last, input logic [23:0] d);
        exp_q.push_back({last, d});
    endtask

    task automatic exp_seq(input logic [23:0] first, input int n, input logic ends_line);
        for (int i = 0; i < n; i++) begin
            exp_push(ends_line && (i == n - 1), first + 24'(i));
        end
    endtask

    task automatic pulse_start();
        @(posedge r_clk);
        #1 line_start = 1'b1;
        @(posedge r_clk);
        #1 line_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge r_clk);
            if (!line_busy && !line_done && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%0b outstanding=%0d, required busy=0 outstanding=0",
                     tag, line_busy, exp_q.size());
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_busy"}, 32'(line_busy), 0);
        check({tag, "_done"}, 32'(line_done), 0);
        check({tag, "_re"}, 32'(fifo_re), 0);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_last"}, 32'(out_last), 0);
        check({tag, "_uflow"}, 32'(underflow), 0);
        check({tag, "_ovrun"}, 32'(overrun), 0);
        check({tag, "_data"}, 32'(out_data), 32'(FILLW));
        check({tag, "_pixcnt"}, 32'(pix_cnt), 0);
    endtask

    // Monitor: pops the scoreboard on every accepted beat and checks hold / done timing.
    initial begin
        logic        hold_pend;
        logic [23:0] hold_data;
        logic        done_due;
        logic [DW:0] e;
        hold_pend = 1'b0;
        hold_data = '0;
        done_due  = 1'b0;
        forever begin
            @(negedge r_clk);
            if (mon_en) begin
                check("line_done_timing", 32'(line_done), 32'(done_due));
                if (hold_pend) begin
                    check("hold_valid", 32'(out_valid), 1);
                    check("hold_data", 32'(out_data), 32'(hold_data));
                end
                if (fifo_re) check("re_while_empty", 32'(fifo_empty), 0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data %0h last %0b, required no beat",
                                 out_data, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", 32'(out_data), 32'(e[DW-1:0]));
                        check("beat_last", 32'(out_last), 32'(e[DW]));
                    end
                end
                hold_pend = out_valid && !out_ready;
                hold_data = out_data;
                done_due  = out_valid && out_ready && out_last;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        r_rst      = 1'b1;
        line_start = 1'b0;
        err_clr    = 1'b0;
        repeat (3) @(posedge r_clk);
        @(negedge r_clk);
        reset_checks("rst");
        @(posedge r_clk);
        #1 r_rst = 1'b0;
        mon_en = 1'b1;

        // 1: basic line, latency and throughput
        fifo_fill(24'h01, 8);
        exp_seq(24'h01, 8, 1'b1);
        pulse_start();
        @(negedge r_clk);
        check("lat_re", 32'(fifo_re), 1);
        check("lat_novalid", 32'(out_valid), 0);
        @(negedge r_clk);
        check("lat_valid", 32'(out_valid), 1);
        for (int k = 1; k < 8; k++) begin
            @(negedge r_clk);
            check("thru_valid", 32'(out_valid), 1);
        end
        @(negedge r_clk);
        check("b_done", 32'(line_done), 1);
        check("b_busy", 32'(line_busy), 0);
        check("b_uflow", 32'(underflow), 0);
        wait_idle("basic");

        // 2: back-pressure
        fifo_fill(24'h11, 8);
        exp_seq(24'h11, 8, 1'b1);
        toggle_en = 1'b1;
        pulse_start();
        wait_idle("bp");
        toggle_en = 1'b0;
        @(posedge r_clk);
        #1;

        // 3: starvation and pad
        fifo_fill(24'h21, 3);
        exp_seq(24'h21, 3, 1'b0);
        for (int i = 0; i < 5; i++) exp_push(i == 4, FILLW);
        pulse_start();
        repeat (7) @(negedge r_clk);
        check("uf_not_yet", 32'(underflow), 0);
        @(negedge r_clk);
        check("uf_set", 32'(underflow), 1);
        wait_idle("pad");
        check("uf_sticky", 32'(underflow), 1);

        // 5: overrun, set-wins-over-clear, back-to-back line, err_clr
        fifo_fill(24'h41, 8);
        fifo_fill(24'h51, 8);
        exp_seq(24'h41, 8, 1'b1);
        pulse_start();
        repeat (3) @(posedge r_clk);
        #1;
        line_start = 1'b1;
        err_clr    = 1'b1;
        @(posedge r_clk);
        #1;
        line_start = 1'b0;
        err_clr    = 1'b0;
        @(negedge r_clk);
        check("ovr_set", 32'(overrun), 1);
        check("uf_cleared", 32'(underflow), 0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge r_clk);
            if (line_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 1);
        exp_seq(24'h51, 8, 1'b1);
        line_start = 1'b1;
        @(posedge r_clk);
        #1 line_start = 1'b0;
        @(negedge r_clk);
        check("b2b_busy", 32'(line_busy), 1);
        wait_idle("b2b");
        @(posedge r_clk);
        #1 err_clr = 1'b1;
        @(posedge r_clk);
        #1 err_clr = 1'b0;
        @(negedge r_clk);
        check("clr_ovr", 32'(overrun), 0);
        check("clr_uf", 32'(underflow), 0);

        // 4: short stall of 3 cycles, no padding
        fifo_fill(24'h31, 4);
        exp_seq(24'h31, 8, 1'b1);
        pulse_start();
        repeat (7) @(posedge r_clk);
        #1 fifo_fill(24'h35, 4);
        wait_idle("stall");
        check("stall_uf", 32'(underflow), 0);

        // 6: reset mid-line after 4 beats
        fifo_fill(24'h61, 8);
        exp_seq(24'h61, 8, 1'b1);
        pulse_start();
        repeat (5) @(negedge r_clk);
        check("mid_pixcnt", 32'(pix_cnt), 4);
        r_rst = 1'b1;
        @(posedge r_clk);
        #1;
        r_rst = 1'b0;
        exp_q.delete();
        @(negedge r_clk);
        reset_checks("midrst");
        fifo_fill(24'h71, 4);
        exp_seq(24'h65, 4, 1'b0);
        exp_seq(24'h71, 4, 1'b1);
        pulse_start();
        wait_idle("after_rst");
        check("after_rst_uf", 32'(underflow), 0);

        repeat (2) @(negedge r_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
